// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, frame geometry and
// parity-type constants common to the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // 50 MHz system clock at 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int DATA_BITS            = 8;

  // Parity type: EVEN -> parity bit = ^data, ODD -> parity bit = ~^data.
  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to 1 so the receiver sees an idle (high) line while coming out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Shift the raw line through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, optional parity bit,
// 1 stop bit. Bits are sampled at their midpoint; a good frame yields a
// one-cycle data_valid strobe, a bad stop bit a one-cycle frame_err strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int   CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic PAR_EN       = 1'b0,
  parameter logic PAR_TYP      = EVEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] p_data,
  output logic                 data_valid,
  output logic                 par_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  // The start bit is checked half a bit in, so every later sample falls
  // one full bit period later, i.e. at the middle of each bit.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_t          r_state;
  uart_state_t          w_state_next;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par_bad;
  logic [DATA_BITS-1:0] r_p_data;
  logic                 r_data_valid;
  logic                 r_par_err;
  logic                 r_frame_err;
  logic                 w_rx_s;
  logic                 w_cnt_max;
  logic                 w_cnt_half;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx_in),
    .o_sync  (w_rx_s)
  );

  assign w_cnt_max  = (r_cnt == CNT_MAX);
  assign w_cnt_half = (r_cnt == CNT_HALF);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; STOP returns to IDLE mid stop bit so a start edge
  // immediately following the stop bit is not missed.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_rx_s) w_state_next = START;
      START:   if (w_cnt_half) w_state_next = w_rx_s ? IDLE : DATA;
      DATA:    if (w_cnt_max && (r_bit_idx == LAST_IDX))
                 w_state_next = PAR_EN ? PARITY : STOP;
      PARITY:  if (w_cnt_max) w_state_next = STOP;
      STOP:    if (w_cnt_max) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Bit-period counter: cleared on every state change, otherwise wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_cnt <= '0;
    else if (w_state_next != r_state) r_cnt <= '0;
    else if (w_cnt_max)               r_cnt <= '0;
    else                              r_cnt <= r_cnt + 1'b1;
  end

  // Data path: bit index, shift register and parity check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      case (r_state)
        START: r_bit_idx <= '0;
        DATA: if (w_cnt_max) begin
          r_shreg[r_bit_idx] <= w_rx_s;
          r_bit_idx          <= r_bit_idx + 3'd1;
        end
        PARITY: if (w_cnt_max) r_par_bad <= w_rx_s ^ (^r_shreg) ^ PAR_TYP;
        default: ;
      endcase
    end
  end

  // Output strobes and the held byte, registered off the stop-bit sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_frame_err  <= 1'b0;
      if ((r_state == STOP) && w_cnt_max) begin
        if (w_rx_s) begin
          r_p_data     <= r_shreg;
          r_data_valid <= 1'b1;
          r_par_err    <= PAR_EN & r_par_bad;
        end else begin
          r_frame_err  <= 1'b1;
        end
      end
    end
  end

  assign p_data     = r_p_data;
  assign data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one receiver without parity on line A and an
// even- and an odd-parity receiver sharing line B.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  logic [7:0] p_a, p_e, p_o;
  logic dv_a, pe_a, fe_a, bz_a;
  logic dv_e, pe_e, fe_e, bz_e;
  logic dv_o, pe_o, fe_o, bz_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       dv;
    logic       pe;
    logic       fe;
    time        t;
  } ev_t;

  ev_t qa[$];
  ev_t qe[$];
  ev_t qo[$];

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .PAR_EN(1'b0), .PAR_TYP(EVEN)) dut_a (
    .clk(clk), .rst(rst), .rx_in(rx_a), .p_data(p_a), .data_valid(dv_a),
    .par_err(pe_a), .frame_err(fe_a), .busy(bz_a));
  uart_rx #(.CLKS_PER_BIT(CPB), .PAR_EN(1'b1), .PAR_TYP(EVEN)) dut_e (
    .clk(clk), .rst(rst), .rx_in(rx_b), .p_data(p_e), .data_valid(dv_e),
    .par_err(pe_e), .frame_err(fe_e), .busy(bz_e));
  uart_rx #(.CLKS_PER_BIT(CPB), .PAR_EN(1'b1), .PAR_TYP(ODD)) dut_o (
    .clk(clk), .rst(rst), .rx_in(rx_b), .p_data(p_o), .data_valid(dv_o),
    .par_err(pe_o), .frame_err(fe_o), .busy(bz_o));

  // Record every strobe cycle of each receiver.
  always @(negedge clk) begin
    if (dv_a || pe_a || fe_a) qa.push_back('{p_a, dv_a, pe_a, fe_a, $time});
    if (dv_e || pe_e || fe_e) qe.push_back('{p_e, dv_e, pe_e, fe_e, $time});
    if (dv_o || pe_o || fe_o) qo.push_back('{p_o, dv_o, pe_o, fe_o, $time});
  end

  task automatic put_bit(input bit on_b, input logic v);
    if (on_b) rx_b = v;
    else      rx_a = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input bit on_b, input logic [7:0] d, input bit with_par,
                            input logic par_bit, input logic stop_bit);
    put_bit(on_b, 1'b0);
    for (int i = 0; i < 8; i++) put_bit(on_b, d[i]);
    if (with_par) put_bit(on_b, par_bit);
    put_bit(on_b, stop_bit);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rx_a = 1'($urandom);
      rx_b = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({p_a, dv_a, pe_a, fe_a, bz_a} !== 12'h000 || {p_e, dv_e, pe_e, fe_e, bz_e} !== 12'h000) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: a=%h/%b%b%b%b e=%h/%b%b%b%b required all 0",
                 i, p_a, dv_a, pe_a, fe_a, bz_a, p_e, dv_e, pe_e, fe_e, bz_e);
      end
    end
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qe.size() != 0 || qo.size() != 0) begin
      errors++;
      $display("FAIL reset_no_strobe: events a=%0d e=%0d o=%0d required 0", qa.size(), qe.size(), qo.size());
    end
    $display("test_reset: done");
  endtask

  task automatic test_idle();
    int busy_seen = 0;
    for (int i = 0; i < 20 * CPB; i++) begin
      @(negedge clk);
      if (bz_a || bz_e || bz_o) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL idle_busy: busy cycles %0d required 0", busy_seen);
    end
    checks++;
    if (qa.size() + qe.size() + qo.size() != 0) begin
      errors++;
      $display("FAIL idle_no_strobe: events %0d required 0", qa.size() + qe.size() + qo.size());
    end
    $display("test_idle: done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    ev_t ev;
    time t0;
    int lat;
    exp_q = '{8'hA5, 8'h00, 8'hFF};
    for (int i = 0; i < 400; i++) exp_q.push_back(8'($urandom));
    t0 = $time;
    foreach (exp_q[i]) send_frame(1'b0, exp_q[i], 1'b0, 1'b0, 1'b1);
    rx_a = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (qa.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes required %0d", qa.size(), exp_q.size());
    end
    checks++;
    if (qa.size() == 0) begin
      errors++;
      $display("FAIL b2b_latency: no strobe required one at 79 cycles");
    end else begin
      lat = int'((qa[0].t - t0) / 10);
      if (lat < 78 || lat > 80) begin
        errors++;
        $display("FAIL b2b_latency: got %0d cycles required 79 +/-1", lat);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      b = exp_q[i];
      if (qa.size() == 0) break;
      ev = qa.pop_front();
      checks++;
      if (ev.data !== b || ev.dv !== 1'b1 || ev.pe !== 1'b0 || ev.fe !== 1'b0) begin
        errors++;
        $display("FAIL b2b_byte %0d: got %h dv=%b pe=%b fe=%b required %h dv=1 pe=0 fe=0",
                 i, ev.data, ev.dv, ev.pe, ev.fe, b);
      end
    end
    qa.delete();
    $display("test_back_to_back: %0d bytes sent", exp_q.size());
  endtask

  task automatic test_glitch();
    ev_t ev;
    rx_a = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (bz_a !== 1'b0 || qa.size() != 0) begin
      errors++;
      $display("FAIL glitch_reject: busy=%b events=%0d required busy=0 events=0", bz_a, qa.size());
    end
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (qa.size() != 1) begin
      errors++;
      $display("FAIL glitch_next_frame: got %0d strobes required 1", qa.size());
    end else begin
      ev = qa.pop_front();
      if (ev.data !== 8'h3C || ev.dv !== 1'b1 || ev.pe !== 1'b0 || ev.fe !== 1'b0) begin
        errors++;
        $display("FAIL glitch_next_frame: got %h dv=%b pe=%b fe=%b required 3c dv=1 pe=0 fe=0",
                 ev.data, ev.dv, ev.pe, ev.fe);
      end
    end
    qa.delete();
    $display("test_glitch: done");
  endtask

  task automatic test_framing();
    ev_t ev;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    rx_a = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (qa.size() != 1) begin
      errors++;
      $display("FAIL framing_strobe: got %0d strobes required 1", qa.size());
    end else begin
      ev = qa.pop_front();
      if (ev.data !== 8'h3C || ev.dv !== 1'b0 || ev.pe !== 1'b0 || ev.fe !== 1'b1) begin
        errors++;
        $display("FAIL framing_strobe: got %h dv=%b pe=%b fe=%b required 3c dv=0 pe=0 fe=1",
                 ev.data, ev.dv, ev.pe, ev.fe);
      end
    end
    checks++;
    if (bz_a !== 1'b0 || p_a !== 8'h3C) begin
      errors++;
      $display("FAIL framing_hold: busy=%b p_data=%h required busy=0 p_data=3c", bz_a, p_a);
    end
    qa.delete();
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (qa.size() != 1) begin
      errors++;
      $display("FAIL framing_recover: got %0d strobes required 1", qa.size());
    end else begin
      ev = qa.pop_front();
      if (ev.data !== 8'h81 || ev.dv !== 1'b1 || ev.fe !== 1'b0) begin
        errors++;
        $display("FAIL framing_recover: got %h dv=%b fe=%b required 81 dv=1 fe=0", ev.data, ev.dv, ev.fe);
      end
    end
    qa.delete();
    $display("test_framing: done");
  endtask

  // Sends 8'h07 on line B with the given parity bit; ^8'h07 = 1, so bit 1 is
  // correct even parity and bit 0 is correct odd parity.
  task automatic test_parity(input logic par_bit, input logic exp_pe_even, input logic exp_pe_odd);
    ev_t ev;
    send_frame(1'b1, 8'h07, 1'b1, par_bit, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (qe.size() != 1) begin
      errors++;
      $display("FAIL parity_even bit=%b: got %0d strobes required 1", par_bit, qe.size());
    end else begin
      ev = qe.pop_front();
      if (ev.data !== 8'h07 || ev.dv !== 1'b1 || ev.pe !== exp_pe_even || ev.fe !== 1'b0) begin
        errors++;
        $display("FAIL parity_even bit=%b: got %h dv=%b pe=%b fe=%b required 07 dv=1 pe=%b fe=0",
                 par_bit, ev.data, ev.dv, ev.pe, ev.fe, exp_pe_even);
      end
    end
    checks++;
    if (qo.size() != 1) begin
      errors++;
      $display("FAIL parity_odd bit=%b: got %0d strobes required 1", par_bit, qo.size());
    end else begin
      ev = qo.pop_front();
      if (ev.data !== 8'h07 || ev.dv !== 1'b1 || ev.pe !== exp_pe_odd || ev.fe !== 1'b0) begin
        errors++;
        $display("FAIL parity_odd bit=%b: got %h dv=%b pe=%b fe=%b required 07 dv=1 pe=%b fe=0",
                 par_bit, ev.data, ev.dv, ev.pe, ev.fe, exp_pe_odd);
      end
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL parity_line_a_quiet: events %0d required 0", qa.size());
    end
    qe.delete();
    qo.delete();
    $display("test_parity: parity bit %b done", par_bit);
  endtask

  task automatic test_reset_mid_frame();
    rx_b = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_b = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if (bz_e !== 1'b1 || bz_o !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: busy e=%b o=%b required 1", bz_e, bz_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bz_e !== 1'b0 || bz_o !== 1'b0 || p_e !== 8'h00) begin
      errors++;
      $display("FAIL midframe_abort: busy e=%b o=%b p_data=%h required 0 0 00", bz_e, bz_o, p_e);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    checks++;
    if (qe.size() + qo.size() + qa.size() != 0 || bz_e !== 1'b0) begin
      errors++;
      $display("FAIL midframe_no_strobe: events %0d busy=%b required 0 0",
               qe.size() + qo.size() + qa.size(), bz_e);
    end
    $display("test_reset_mid_frame: done");
    test_parity(1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_parity(1'b1, 1'b0, 1'b1);
    test_parity(1'b0, 1'b1, 1'b0);
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
